// File: rtl/conv_pkg.sv
// conv2_mac_pipe shared widths and index helpers.
// Maps kernel taps and window activations onto the flat bus bit slices.
package conv_pkg;

  localparam int CH_NUM       = 4;
  localparam int ACT_PER_ADDR = 4;
  localparam int BW_PER_ACT   = 8;
  localparam int BW_PER_PARAM = 8;

  localparam int ACC_W  = 24;
  localparam int PROD_W = 16;
  localparam int KER_N  = 36;
  localparam int PSUM_W = 20;
  localparam int SUM_W  = 22;
  localparam int N_OUT  = 4;

  localparam int BANK_W = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
  localparam int KER_W  = KER_N * BW_PER_PARAM;
  localparam int WIN_W  = 4 * BANK_W;

  function automatic int w_idx(input int ch, input int ky,
                               input int kx);
    return 9 * ch + 3 * ky + kx;
  endfunction

  function automatic int w_msb(input int ch, input int ky,
                               input int kx);
    return KER_W - 1 - BW_PER_PARAM * w_idx(ch, ky, kx);
  endfunction

  function automatic int act_bank(input int y, input int x);
    return 2 * (y / 2) + x / 2;
  endfunction

  function automatic int act_msb(input int y, input int x,
                                 input int ch);
    return BANK_W - 1 - ch * ACT_PER_ADDR * BW_PER_ACT
           - BW_PER_ACT * (2 * (y % 2) + x % 2);
  endfunction

  // MSB inside the concatenation {b0, b1, b2, b3}
  function automatic int win_msb(input int y, input int x,
                                 input int ch);
    return (3 - act_bank(y, x)) * BANK_W + act_msb(y, x, ch);
  endfunction

endpackage

// File: rtl/conv2_mac_pipe_if.sv
// conv2_mac_pipe bus: window/kernel load inputs, result outputs.
// master = controller side, slave = datapath side.
interface conv2_mac_pipe_if;
  import conv_pkg::*;

  logic                    in_valid;
  logic [BANK_W-1:0]       tmp_b0;
  logic [BANK_W-1:0]       tmp_b1;
  logic [BANK_W-1:0]       tmp_b2;
  logic [BANK_W-1:0]       tmp_b3;
  logic                    wr_w;
  logic [KER_W-1:0]        weight_wdata;
  logic                    wr_b;
  logic [BW_PER_PARAM-1:0] bias_wdata;
  logic                    swap;
  logic                    out_valid;
  logic [BW_PER_ACT-1:0]   pipe3_c0;
  logic [BW_PER_ACT-1:0]   pipe3_c1;
  logic [BW_PER_ACT-1:0]   pipe3_c2;
  logic [BW_PER_ACT-1:0]   pipe3_c3;

  modport master (
    output in_valid, tmp_b0, tmp_b1, tmp_b2, tmp_b3,
    output wr_w, weight_wdata, wr_b, bias_wdata, swap,
    input  out_valid, pipe3_c0, pipe3_c1, pipe3_c2, pipe3_c3
  );

  modport slave (
    input  in_valid, tmp_b0, tmp_b1, tmp_b2, tmp_b3,
    input  wr_w, weight_wdata, wr_b, bias_wdata, swap,
    output out_valid, pipe3_c0, pipe3_c1, pipe3_c2, pipe3_c3
  );

endinterface

// File: rtl/conv_requant.sv
// ReLU, arithmetic shift and saturation of a 24-bit accumulator.
// Ports: acc (signed in) -> q (8-bit out), combinational.
module conv_requant
  import conv_pkg::*;
#(
  parameter int OUT_SHIFT = 7
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic [BW_PER_ACT-1:0]   q
);

  logic signed [ACC_W-1:0] sh;

  assign sh = acc >>> OUT_SHIFT;

  always_comb begin
    q = sh[BW_PER_ACT-1:0];
    if (acc < 0)
      q = '0;
    else if (sh > 24'sd127)
      q = 8'd127;
  end

endmodule

// File: rtl/conv2_mac_pipe.sv
// 3-stage 3x3x4 conv MAC: products -> accumulate+bias -> requant.
// Ports: clk, rst_n, bus (slave: window, kernel/bias load, results).
module conv2_mac_pipe
  import conv_pkg::*;
#(
  parameter int BIAS_SHIFT = 8,
  parameter int OUT_SHIFT  = 7
) (
  input logic             clk,
  input logic             rst_n,
  conv2_mac_pipe_if.slave bus
);

  logic [KER_W-1:0]               sh_w;
  logic [KER_W-1:0]               act_w;
  logic signed [BW_PER_PARAM-1:0] sh_b;
  logic signed [BW_PER_PARAM-1:0] act_b;
  logic [WIN_W-1:0]               win;

  logic signed [PSUM_W-1:0] psum    [N_OUT][CH_NUM];
  logic signed [PSUM_W-1:0] s1_psum [N_OUT][CH_NUM];
  logic signed [BW_PER_PARAM-1:0] s1_bias;
  logic signed [ACC_W-1:0]  acc     [N_OUT];
  logic signed [ACC_W-1:0]  s2_acc  [N_OUT];
  logic [BW_PER_ACT-1:0]    q       [N_OUT];
  logic [BW_PER_ACT-1:0]    s3_q    [N_OUT];
  logic                     s1_v;
  logic                     s2_v;
  logic                     s3_v;

  assign win = {bus.tmp_b0, bus.tmp_b1,
                bus.tmp_b2, bus.tmp_b3};

  // One channel's 3x3 dot product for output (oy, ox)
  function automatic logic signed [PSUM_W-1:0] ch_psum(
    input logic [WIN_W-1:0] w_in,
    input logic [KER_W-1:0] ker,
    input int               oy,
    input int               ox,
    input int               ch
  );
    logic signed [BW_PER_ACT-1:0]   a;
    logic signed [BW_PER_PARAM-1:0] k;
    logic signed [PROD_W-1:0]       p;
    logic signed [PSUM_W-1:0]       s;
    logic [8:0]                     ai;
    logic [8:0]                     ki;
    s = '0;
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        ai = 9'(win_msb(oy + ky, ox + kx, ch));
        ki = 9'(w_msb(ch, ky, kx));
        a  = w_in[ai -: BW_PER_ACT];
        k  = ker[ki -: BW_PER_PARAM];
        p  = PROD_W'(a) * PROD_W'(k);
        s  = s + PSUM_W'(p);
      end
    end
    return s;
  endfunction

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    logic signed [SUM_W-1:0] sum;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      assign psum[o][c] =
        ch_psum(win, act_w, o / 2, o % 2, c);
    end

    always_comb begin
      sum = '0;
      for (int c = 0; c < CH_NUM; c++)
        sum = sum + SUM_W'(s1_psum[o][c]);
    end

    assign acc[o] = ACC_W'(sum)
                  + (ACC_W'(s1_bias) <<< BIAS_SHIFT);

    conv_requant #(
      .OUT_SHIFT(OUT_SHIFT)
    ) u_rq (
      .acc(s2_acc[o]),
      .q  (q[o])
    );
  end

  // Swap with a same-cycle write takes the incoming data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_w  <= '0;
      sh_b  <= '0;
      act_w <= '0;
      act_b <= '0;
    end else begin
      if (bus.wr_w)
        sh_w <= bus.weight_wdata;
      if (bus.wr_b)
        sh_b <= bus.bias_wdata;
      if (bus.swap) begin
        act_w <= bus.wr_w ? bus.weight_wdata : sh_w;
        act_b <= bus.wr_b ? bus.bias_wdata : sh_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s3_v    <= 1'b0;
      s1_bias <= '0;
      for (int o = 0; o < N_OUT; o++) begin
        for (int c = 0; c < CH_NUM; c++)
          s1_psum[o][c] <= '0;
        s2_acc[o] <= '0;
        s3_q[o]   <= '0;
      end
    end else begin
      s1_v <= bus.in_valid;
      s2_v <= s1_v;
      s3_v <= s2_v;
      if (bus.in_valid) begin
        s1_psum <= psum;
        s1_bias <= act_b;
      end
      if (s1_v)
        s2_acc <= acc;
      if (s2_v)
        s3_q <= q;
    end
  end

  assign bus.out_valid = s3_v;
  assign bus.pipe3_c0  = s3_q[0];
  assign bus.pipe3_c1  = s3_q[1];
  assign bus.pipe3_c2  = s3_q[2];
  assign bus.pipe3_c3  = s3_q[3];

endmodule
